// File: rtl/ray_aabb_sched.sv
// Two-requester front end for a fixed-latency Ray_AABB_11_5 core: round-robin arbitration,
// operand register, tag tracking pipeline and an in-order FWFT result FIFO with credit flow control.
module ray_aabb_sched #(
  parameter int unsigned W     = 19,
  parameter int unsigned LAT   = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [9*W-1:0]     req0_box,
  input  logic [2:0]         req0_dir,
  input  logic [3*W-1:0]     req0_inv,
  input  logic [TAG_W-1:0]   req0_tag,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [9*W-1:0]     req1_box,
  input  logic [2:0]         req1_dir,
  input  logic [3*W-1:0]     req1_inv,
  input  logic [TAG_W-1:0]   req1_tag,
  output logic [9*W-1:0]     core_box,
  output logic [2:0]         core_dir,
  output logic [3*W-1:0]     core_inv,
  input  logic               core_hit,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_hit,
  output logic [TAG_W-1:0]   res_tag,
  output logic               res_src,
  output logic               busy
);
  localparam int unsigned IW = $clog2(LAT + 2);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = TAG_W + 2;

  logic             ptr_q;
  logic             gnt0, gnt1, credit_ok, accept, sel;
  logic [31:0]      outstanding;
  logic             stg_vld_q;
  logic [TAG_W-1:0] stg_tag_q;
  logic             stg_src_q;
  logic [LAT-1:0]   trk_vld_q;
  logic [TAG_W-1:0] trk_tag_q [LAT];
  logic [LAT-1:0]   trk_src_q;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    head;
  logic             push, pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits come from registered counts only, so a same-cycle pop frees its slot a cycle later.
  assign outstanding = 32'(inflight_q) + 32'(fifo_cnt_q);
  assign credit_ok   = outstanding < DEPTH;

  always_comb begin
    gnt0 = req0_valid && (!req1_valid || !ptr_q);
    gnt1 = req1_valid && (!req0_valid || ptr_q);
  end

  assign req0_ready = !rst && gnt0 && credit_ok;
  assign req1_ready = !rst && gnt1 && credit_ok;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel        = req1_valid && req1_ready;

  // The stage register rides with core_*, so the last tracking slot lines up with core_hit.
  assign push = trk_vld_q[LAT-1];
  assign pop  = res_valid && res_ready;
  assign head = mem_q[rptr_q];

  assign res_valid = !rst && (fifo_cnt_q != '0);
  assign res_hit   = res_valid && head[EW-1];
  assign res_tag   = res_valid ? head[EW-2:1] : '0;
  assign res_src   = res_valid && head[0];
  assign busy      = !rst && ((inflight_q != '0) || (fifo_cnt_q != '0));

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !push) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!accept && push) begin
      inflight_d = inflight_q - 1'b1;
    end
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 1'b1;
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      stg_vld_q  <= 1'b0;
      trk_vld_q  <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      core_box   <= '0;
      core_dir   <= '0;
      core_inv   <= '0;
    end else begin
      stg_vld_q  <= accept;
      trk_vld_q  <= (trk_vld_q << 1) | LAT'(stg_vld_q);
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (accept) begin
        ptr_q    <= ~sel;
        core_box <= sel ? req1_box : req0_box;
        core_dir <= sel ? req1_dir : req0_dir;
        core_inv <= sel ? req1_inv : req0_inv;
      end
      if (push) wptr_q <= wrap_inc(wptr_q);
      if (pop)  rptr_q <= wrap_inc(rptr_q);
    end
  end

  // Payload path needs no reset: every use is qualified by a valid bit or the FIFO count.
  always_ff @(posedge clk) begin
    if (accept) begin
      stg_tag_q <= sel ? req1_tag : req0_tag;
      stg_src_q <= sel;
    end
    trk_tag_q[0] <= stg_tag_q;
    trk_src_q[0] <= stg_src_q;
    for (int i = 1; i < LAT; i++) begin
      trk_tag_q[i] <= trk_tag_q[i-1];
      trk_src_q[i] <= trk_src_q[i-1];
    end
    if (push && !rst) mem_q[wptr_q] <= {core_hit, trk_tag_q[LAT-1], trk_src_q[LAT-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && fifo_cnt_q == CW'(DEPTH)))
        else $error("ray_aabb_sched: push into full result FIFO");
    end
  end

endmodule

// File: tb/tb_ray_aabb_sched.sv
// Bench for ray_aabb_sched: behavioural fixed-latency core model plus an in-order scoreboard
// filled on every observed accept and drained on every observed result pop.
module tb_ray_aabb_sched;
  localparam int unsigned W     = 19;
  localparam int unsigned LAT   = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned EW    = TAG_W + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [9*W-1:0]   req0_box = '0, req1_box = '0;
  logic [2:0]       req0_dir = '0, req1_dir = '0;
  logic [3*W-1:0]   req0_inv = '0, req1_inv = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic [9*W-1:0]   core_box;
  logic [2:0]       core_dir;
  logic [3*W-1:0]   core_inv;
  logic             core_hit;
  logic             res_valid, res_hit, res_src, busy;
  logic             res_ready = 1'b0;
  logic [TAG_W-1:0] res_tag;

  int tests = 0;
  int fails = 0;
  int n_results = 0;
  logic [EW-1:0] sb [$];
  logic [EW-1:0] exp_e;
  logic [9*W-1:0] one_box = 1;
  logic [LAT-1:0] hit_pipe = '0;

  always #5 clk = ~clk;

  ray_aabb_sched #(.W(W), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_box(req0_box),
    .req0_dir(req0_dir), .req0_inv(req0_inv), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_box(req1_box),
    .req1_dir(req1_dir), .req1_inv(req1_inv), .req1_tag(req1_tag),
    .core_box(core_box), .core_dir(core_dir), .core_inv(core_inv), .core_hit(core_hit),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_tag(res_tag),
    .res_src(res_src), .busy(busy)
  );

  // Stand-in core: hit is the parity of all operands, returned LAT cycles after core_* show it.
  function automatic logic core_fn(input logic [9*W-1:0] b, input logic [2:0] d,
                                   input logic [3*W-1:0] v);
    return ^b ^ ^d ^ ^v;
  endfunction

  always @(posedge clk) hit_pipe <= {hit_pipe[LAT-2:0], core_fn(core_box, core_dir, core_inv)};
  assign core_hit = hit_pipe[LAT-1];

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (req0_ready && req1_ready) begin
        fails++;
        $display("FAIL one_grant: got ready0/ready1 1/1, want at most one");
      end
      if (req0_valid && req0_ready) sb.push_back({core_fn(req0_box, req0_dir, req0_inv), req0_tag, 1'b0});
      else if (req1_valid && req1_ready) sb.push_back({core_fn(req1_box, req1_dir, req1_inv), req1_tag, 1'b1});
      if (res_valid && res_ready) begin
        tests++;
        n_results++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL result_unexpected: got tag %0d src %0d, want no result", res_tag, res_src);
        end else begin
          exp_e = sb.pop_front();
          if ({res_hit, res_tag, res_src} !== exp_e) begin
            fails++;
            $display("FAIL result: got hit/tag/src %0d/%0d/%0d, want %0d/%0d/%0d",
                     res_hit, res_tag, res_src, exp_e[EW-1], exp_e[EW-2:1], exp_e[0]);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int n, input logic [TAG_W-1:0] t);
    logic [9*W-1:0] b;
    logic [3*W-1:0] v;
    for (int i = 0; i < 9*W; i++) b[i] = 1'($urandom);
    for (int i = 0; i < 3*W; i++) v[i] = 1'($urandom);
    if (n == 0) begin
      req0_valid = 1'b1; req0_tag = t; req0_box = b; req0_dir = 3'($urandom); req0_inv = v;
    end else begin
      req1_valid = 1'b1; req1_tag = t; req1_box = b; req1_dir = 3'($urandom); req1_inv = v;
    end
  endtask

  task automatic drain(input string name);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    for (int n = 0; n < 100 && (sb.size() != 0 || busy !== 1'b0); n++) cyc();
    tests++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain: got %0d pending, busy %b, want 0 pending, busy 0", name, sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b/%b, want 0/0", req0_ready, req1_ready);
    end
    tests++;
    if ({res_valid, res_hit, res_tag, res_src, busy} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %b%b%h%b%b, want all 0", res_valid, res_hit, res_tag, res_src, busy);
    end
    tests++;
    if (core_box !== '0 || core_dir !== '0 || core_inv !== '0) begin
      fails++; $display("FAIL reset_core: got dir %b, want zeroed core operands", core_dir);
    end
    cyc();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL post_reset: got res_valid %b busy %b, want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_single();
    cyc();
    set_job(0, 4'd5);
    req0_box = one_box; req0_dir = '0; req0_inv = '0;
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL single_accept: got ready %b, want 1", req0_ready);
    end
    cyc();
    req0_valid = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        tests++;
        if (core_box !== one_box || core_dir !== 3'b000 || core_inv !== '0) begin
          fails++; $display("FAIL single_core_c%0d: got box lsb %b dir %b, want 1 000", k, core_box[0], core_dir);
        end
      end
      tests++;
      if (k < LAT + 2) begin
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
          fails++; $display("FAIL single_early_c%0d: got res_valid %b busy %b, want 0 1", k, res_valid, busy);
        end
      end else if ({res_valid, res_hit, res_tag, res_src} !== {1'b1, 1'b1, 4'd5, 1'b0}) begin
        fails++;
        $display("FAIL single_result: got v/hit/tag/src %b/%b/%0d/%b, want 1/1/5/0",
                 res_valid, res_hit, res_tag, res_src);
      end
      if (k < LAT + 2) cyc();
    end
    cyc();
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_pop: got res_valid %b busy %b, want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_arbitration();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_job(0, 4'(2 * i));
      set_job(1, 4'(2 * i + 1));
      @(negedge clk);
      tests++;
      if (req0_ready !== 1'(i % 2 == 0) || req1_ready !== 1'(i % 2 == 1)) begin
        fails++;
        $display("FAIL arb_grant_%0d: got ready0/ready1 %b/%b, want %b/%b",
                 i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
      end
      cyc();
    end
    drain("arb");
  endtask

  task automatic test_lone();
    res_ready = 1'b1;
    set_job(0, 4'd11);
    cyc();
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_job(1, 4'(12 + i));
      @(negedge clk);
      tests++;
      if (req1_ready !== 1'b1) begin
        fails++; $display("FAIL lone_accept_%0d: got ready1 %b, want 1", i, req1_ready);
      end
      cyc();
    end
    set_job(0, 4'd1);
    set_job(1, 4'd2);
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL lone_pointer: got ready0/ready1 %b/%b, want 1/0", req0_ready, req1_ready);
    end
    cyc();
    drain("lone");
  endtask

  task automatic test_backpressure();
    int n_acc;
    n_acc = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_job(0, 4'(i));
      set_job(1, 4'(i + 8));
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) n_acc++;
      cyc();
    end
    tests++;
    if (n_acc != DEPTH) begin
      fails++; $display("FAIL bp_accepts: got %0d, want %0d", n_acc, DEPTH);
    end
    res_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_pop_cycle: got ready0/ready1/res_valid %b/%b/%b, want 0/0/1",
               req0_ready, req1_ready, res_valid);
    end
    cyc();
    res_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) n_acc++;
      cyc();
    end
    tests++;
    if (n_acc != 1) begin
      fails++; $display("FAIL bp_after_pop: got %0d accepts, want 1", n_acc);
    end
    drain("bp");
  endtask

  task automatic test_stream();
    int n_acc;
    int start;
    n_acc = 0;
    start = n_results;
    res_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      set_job(0, 4'(n_acc));
      @(negedge clk);
      if (req0_valid && req0_ready) n_acc++;
      cyc();
    end
    drain("stream");
    tests++;
    if (n_acc < 40 || n_results - start != n_acc) begin
      fails++;
      $display("FAIL stream_count: got %0d accepts %0d results, want >=40 and equal",
               n_acc, n_results - start);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_job(0, 4'(i + 1));
      cyc();
    end
    req0_valid = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    sb.delete();
    set_job(0, 4'd7);
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b0) begin
      fails++; $display("FAIL mid_reset_ready: got %b, want 0", req0_ready);
    end
    cyc();
    rst = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      fails++; $display("FAIL mid_after_reset: got busy %b res_valid %b, want 0 0", busy, res_valid);
    end
    seen = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      cyc();
      @(negedge clk);
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++; $display("FAIL mid_discard: got res_valid 1 for discarded jobs, want 0");
    end
    cyc();
    set_job(0, 4'd9);
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL mid_new_accept: got ready %b, want 1", req0_ready);
    end
    cyc();
    req0_valid = 1'b0;
    seen = 1'b0;
    for (int k = 1; k < LAT + 2; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen = 1'b1;
      cyc();
    end
    @(negedge clk);
    tests++;
    if (seen || {res_valid, res_tag, res_src} !== {1'b1, 4'd9, 1'b0}) begin
      fails++;
      $display("FAIL mid_new_result: got early %b v/tag/src %b/%0d/%b, want 0 1/9/0",
               seen, res_valid, res_tag, res_src);
    end
    cyc();
    drain("mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_lone();
    test_backpressure();
    test_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
